// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers horizontal/vertical position from active-low
// hsync/vsync, tracks timing lock over consecutive clean frames, and flags
// any timing violation seen while acquiring or locked. All state moves only
// on i_pix_en strobes.
// Optional per-frame pixel counter enabled by defining VGA_RX_PIXEL_COUNT_EN;
// without it o_pixel_count is tied to zero.
module vga_sync_receiver #(
  parameter int P_H_TOTAL      = 800,
  parameter int P_V_TOTAL      = 525,
  parameter int P_H_ACTIVE     = 640,
  parameter int P_V_ACTIVE     = 480,
  parameter int P_H_SYNC_START = 656,
  parameter int P_V_SYNC_START = 490,
  parameter int P_LOCK_FRAMES  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pix_en,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_pixel_on,
  output logic [10:0] o_hcounter,
  output logic [10:0] o_vcounter,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic        o_sync_error,
  output logic [18:0] o_pixel_count
);

  localparam logic [10:0] H_LAST  = 11'(P_H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(P_V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(P_H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(P_V_ACTIVE);
  localparam logic [10:0] H_SYNC  = 11'(P_H_SYNC_START);
  localparam logic [10:0] V_SYNC  = 11'(P_V_SYNC_START);
  localparam bit          LOCK_ON_FIRST = (P_LOCK_FRAMES <= 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state;
  logic [7:0]  good_cnt;
  int          good_plus;

  // sync sample stage (one register, advanced on strobes only)
  logic        hsync_p0;
  logic        vsync_p0;

  logic        hs_fall;
  logic        vs_fall;
  logic        h_wrap;
  logic [10:0] h_inc;
  logic [10:0] v_inc;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        h_err;
  logic        v_err;
  logic        sync_err;
  logic        lock_nxt;
  logic        active_nxt;
  logic        frame_nxt;

  // Predicted position, sync-edge realignment and lock outcome for this strobe
  always_comb begin
    hs_fall    = hsync_p0 & ~i_hsync;
    vs_fall    = vsync_p0 & ~i_vsync;
    h_wrap     = (o_hcounter == H_LAST);
    h_inc      = h_wrap ? 11'd0 : o_hcounter + 11'd1;
    v_inc      = o_vcounter;
    if (h_wrap) begin
      v_inc = (o_vcounter == V_LAST) ? 11'd0 : o_vcounter + 11'd1;
    end
    h_nxt      = hs_fall ? H_SYNC : h_inc;
    v_nxt      = vs_fall ? V_SYNC : v_inc;
    h_err      = hs_fall && (h_inc != H_SYNC);
    v_err      = vs_fall && (v_inc != V_SYNC);
    sync_err   = (state != SEARCH) && (h_err || v_err);
    good_plus  = int'(good_cnt) + 1;
    lock_nxt   = 1'b0;
    case (state)
      SEARCH:  lock_nxt = vs_fall && LOCK_ON_FIRST;
      ACQUIRE: lock_nxt = !sync_err && vs_fall && (good_plus >= P_LOCK_FRAMES);
      LOCKED:  lock_nxt = !sync_err;
      default: lock_nxt = 1'b0;
    endcase
    active_nxt = lock_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
    frame_nxt  = lock_nxt && (h_nxt == 11'd0) && (v_nxt == 11'd0);
  end

  // Lock FSM: search for a vsync edge, count clean frames, drop on any error
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= SEARCH;
      good_cnt     <= '0;
      o_locked     <= 1'b0;
      o_sync_error <= 1'b0;
    end else if (i_pix_en) begin
      o_locked     <= lock_nxt;
      o_sync_error <= o_sync_error | sync_err;
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            good_cnt <= 8'd1;
            state    <= LOCK_ON_FIRST ? LOCKED : ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (sync_err) begin
            state    <= SEARCH;
            good_cnt <= '0;
          end else if (vs_fall) begin
            good_cnt <= good_cnt + 8'd1;
            if (good_plus >= P_LOCK_FRAMES) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (sync_err) begin
            state    <= SEARCH;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
        end
      endcase
    end
  end

  // Position counters, sync samples and per-strobe status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hsync_p0      <= 1'b1;
      vsync_p0      <= 1'b1;
      o_hcounter    <= '0;
      o_vcounter    <= '0;
      o_active      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      if (i_pix_en) begin
        hsync_p0      <= i_hsync;
        vsync_p0      <= i_vsync;
        o_hcounter    <= h_nxt;
        o_vcounter    <= v_nxt;
        o_active      <= active_nxt;
        o_frame_start <= frame_nxt;
      end
    end
  end

`ifdef VGA_RX_PIXEL_COUNT_EN
  logic [18:0] pix_acc;
  logic        pix_hit;

  function automatic logic [18:0] sat_inc(input logic [18:0] a);
    return (&a) ? a : a + 19'd1;
  endfunction

  assign pix_hit = active_nxt & i_pixel_on;

  // Per-frame lit-pixel accumulator; the frame-start pixel opens the new frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pix_acc       <= '0;
      o_pixel_count <= '0;
    end else if (i_pix_en) begin
      if (!lock_nxt) begin
        pix_acc <= '0;
      end else if (frame_nxt) begin
        o_pixel_count <= pix_acc;
        pix_acc       <= {18'd0, pix_hit};
      end else if (pix_hit) begin
        pix_acc <= sat_inc(pix_acc);
      end
    end
  end
`else
  logic pixel_on_unused;

  assign pixel_on_unused = i_pixel_on;
  assign o_pixel_count   = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced raster (20x16 total, 12x10 visible)
// with i_pix_en every 4th clock. A timing generator drives sync and pixel data
// and pushes each completed frame's expected pixel count into a scoreboard.
module tb_vga_sync_receiver;

  localparam int HT    = 20;
  localparam int VT    = 16;
  localparam int HA    = 12;
  localparam int VA    = 10;
  localparam int HSS   = 14;
  localparam int VSS   = 12;
  localparam int HS_W  = 3;
  localparam int VS_W  = 2;
  localparam int LF    = 2;
  localparam int FRAME = HT * VT;
  localparam int NPIX  = 50;
  localparam int SHORT_V = 3;
`ifdef VGA_RX_PIXEL_COUNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif
  localparam int EXP_FULL = PC_EN ? HA * VA : 0;

  logic        clk = 1'b0;
  logic        i_reset, i_pix_en, i_hsync, i_vsync, i_pixel_on;
  logic [10:0] o_hcounter, o_vcounter;
  logic        o_active, o_locked, o_frame_start, o_sync_error;
  logic [18:0] o_pixel_count;

  int n_cmp = 0;
  int n_fail = 0;

  // generator state
  int gh = 0, gv = 0, cur_h = 0, cur_v = 0, mode = 0, pix_cnt = 0;
  bit short_pend = 0, skip_pend = 0, prev_vs = 1, drv_vfall = 0;
  bit sb_arm = 0, frame_full = 0;
  int sb_q[$];

  vga_sync_receiver #(
    .P_H_TOTAL(HT), .P_V_TOTAL(VT), .P_H_ACTIVE(HA), .P_V_ACTIVE(VA),
    .P_H_SYNC_START(HSS), .P_V_SYNC_START(VSS), .P_LOCK_FRAMES(LF)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pix_en(i_pix_en),
    .i_hsync(i_hsync), .i_vsync(i_vsync), .i_pixel_on(i_pixel_on),
    .o_hcounter(o_hcounter), .o_vcounter(o_vcounter), .o_active(o_active),
    .o_locked(o_locked), .o_frame_start(o_frame_start),
    .o_sync_error(o_sync_error), .o_pixel_count(o_pixel_count)
  );

  always #5 clk = ~clk;

  // One pixel strobe: three idle clocks, then drive position (gh,gv) with
  // i_pix_en high; returns 1 time unit after the capturing edge.
  task automatic step();
    bit hs, vs, pon, act;
    repeat (3) @(posedge clk);
    #1;
    act = (gh < HA) && (gv < VA);
    hs  = !(gh >= HSS && gh < HSS + HS_W);
    vs  = !(gv >= VSS && gv < VSS + VS_W);
    case (mode)
      1:       pon = 1'b1;
      2:       pon = act && (gv * HA + gh < NPIX);
      default: pon = 1'b0;
    endcase
    drv_vfall = prev_vs && !vs;
    prev_vs   = vs;
    if (gh == 0 && gv == 0) begin
      if (sb_arm && frame_full) sb_q.push_back(PC_EN ? pix_cnt : 0);
      frame_full = sb_arm;
      pix_cnt    = 0;
    end
    if (act && pon) pix_cnt++;
    cur_h = gh;
    cur_v = gv;
    i_hsync = hs; i_vsync = vs; i_pixel_on = pon; i_pix_en = 1'b1;
    if (gh == ((short_pend && gv == SHORT_V) ? HT - 2 : HT - 1)) begin
      if (short_pend && gv == SHORT_V) short_pend = 0;
      gh = 0;
      if (skip_pend && gv == VSS - 2) begin
        gv = VSS;
        skip_pend = 0;
      end else begin
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end else begin
      gh++;
    end
    @(posedge clk);
    #1;
    i_pix_en = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o_hcounter !== 11'd0) begin n_fail++; $display("FAIL reset_h: got %0d want 0", o_hcounter); end
    n_cmp++; if (o_vcounter !== 11'd0) begin n_fail++; $display("FAIL reset_v: got %0d want 0", o_vcounter); end
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b want 0", o_active); end
    n_cmp++; if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %0b want 0", o_frame_start); end
    n_cmp++; if (o_sync_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", o_sync_error); end
    n_cmp++; if (o_pixel_count !== 19'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", o_pixel_count); end
    i_reset = 1'b0;
  endtask

  task automatic test_lock();
    int edges = 0;
    for (int i = 0; i < 4 * FRAME && edges < 2; i++) begin
      step();
      if (drv_vfall) begin
        edges++;
        if (edges == 1) begin
          n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL lock_1st_edge: got %0b want 0", o_locked); end
        end else begin
          n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock_2nd_edge: got %0b want 1", o_locked); end
        end
      end
    end
    n_cmp++; if (edges != 2) begin n_fail++; $display("FAIL lock_timeout: edges %0d want 2", edges); end
    n_cmp++; if (o_sync_error !== 1'b0) begin n_fail++; $display("FAIL lock_err: got %0b want 0", o_sync_error); end
    n_cmp++; if (o_vcounter !== 11'(VSS)) begin n_fail++; $display("FAIL lock_v: got %0d want %0d", o_vcounter, VSS); end
    n_cmp++; if (o_hcounter !== 11'd0) begin n_fail++; $display("FAIL lock_h: got %0d want 0", o_hcounter); end
  endtask

  task automatic test_active();
    bit exp_act, exp_fs;
    for (int i = 0; i < FRAME; i++) begin
      step();
      exp_act = (cur_h < HA) && (cur_v < VA);
      exp_fs  = (cur_h == 0) && (cur_v == 0);
      n_cmp++; if (o_hcounter !== 11'(cur_h)) begin n_fail++; $display("FAIL act_h: got %0d want %0d", o_hcounter, cur_h); end
      n_cmp++; if (o_vcounter !== 11'(cur_v)) begin n_fail++; $display("FAIL act_v: got %0d want %0d", o_vcounter, cur_v); end
      n_cmp++; if (o_active !== exp_act) begin n_fail++; $display("FAIL act_active at (%0d,%0d): got %0b want %0b", cur_h, cur_v, o_active, exp_act); end
      n_cmp++; if (o_frame_start !== exp_fs) begin n_fail++; $display("FAIL act_fs at (%0d,%0d): got %0b want %0b", cur_h, cur_v, o_frame_start, exp_fs); end
    end
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL act_locked: got %0b want 1", o_locked); end
  endtask

  task automatic test_pixel_count();
    int pops = 0;
    int exp;
    sb_arm = 1;
    for (int i = 0; i < 6 * FRAME; i++) begin
      mode = (i < 3 * FRAME) ? 2 : 1;
      step();
      if (o_frame_start === 1'b1 && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        pops++;
        n_cmp++; if (o_pixel_count !== 19'(exp)) begin n_fail++; $display("FAIL pix_count: got %0d want %0d", o_pixel_count, exp); end
      end
    end
    sb_arm = 0;
    frame_full = 0;
    n_cmp++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL pix_pending: %0d frames unmatched want 0", sb_q.size()); end
    n_cmp++; if (pops < 4) begin n_fail++; $display("FAIL pix_frames: %0d compared want >=4", pops); end
  endtask

  task automatic test_short_line();
    int edges = 0;
    bit seen = 0;
    short_pend = 1;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      step();
      seen = (o_sync_error === 1'b1);
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL short_err: got 0 want 1"); end
    n_cmp++; if (cur_h != HSS || cur_v != SHORT_V + 1) begin n_fail++; $display("FAIL short_where: got (%0d,%0d) want (%0d,%0d)", cur_h, cur_v, HSS, SHORT_V + 1); end
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL short_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_hcounter !== 11'(HSS)) begin n_fail++; $display("FAIL short_h: got %0d want %0d", o_hcounter, HSS); end
    for (int i = 0; i < 4 * FRAME && edges < 2; i++) begin
      step();
      if (drv_vfall) begin
        edges++;
        if (edges == 1) begin
          n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL relock_1st: got %0b want 0", o_locked); end
        end else begin
          n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL relock_2nd: got %0b want 1", o_locked); end
        end
      end
    end
    n_cmp++; if (edges != 2) begin n_fail++; $display("FAIL relock_timeout: edges %0d want 2", edges); end
    n_cmp++; if (o_sync_error !== 1'b1) begin n_fail++; $display("FAIL short_sticky: got %0b want 1", o_sync_error); end
  endtask

  task automatic test_mid_reset();
    int edges = 0;
    for (int i = 0; i < 2 * FRAME && !(cur_v == 3 && cur_h == 5); i++) step();
    n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL mid_pre_locked: got %0b want 1", o_locked); end
    i_reset  = 1'b1;
    i_pix_en = 1'b1;
    @(posedge clk);
    #1;
    i_reset  = 1'b0;
    i_pix_en = 1'b0;
    n_cmp++; if (o_hcounter !== 11'd0) begin n_fail++; $display("FAIL mid_h: got %0d want 0", o_hcounter); end
    n_cmp++; if (o_vcounter !== 11'd0) begin n_fail++; $display("FAIL mid_v: got %0d want 0", o_vcounter); end
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL mid_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL mid_active: got %0b want 0", o_active); end
    n_cmp++; if (o_frame_start !== 1'b0) begin n_fail++; $display("FAIL mid_fs: got %0b want 0", o_frame_start); end
    n_cmp++; if (o_sync_error !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %0b want 0", o_sync_error); end
    n_cmp++; if (o_pixel_count !== 19'd0) begin n_fail++; $display("FAIL mid_pc: got %0d want 0", o_pixel_count); end
    for (int i = 0; i < 4 * FRAME && edges < 2; i++) begin
      step();
      if (drv_vfall) begin
        edges++;
        if (edges == 1) begin
          n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL mid_relock_1st: got %0b want 0", o_locked); end
        end else begin
          n_cmp++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock_2nd: got %0b want 1", o_locked); end
        end
      end
    end
    n_cmp++; if (edges != 2) begin n_fail++; $display("FAIL mid_relock_timeout: edges %0d want 2", edges); end
    n_cmp++; if (o_sync_error !== 1'b0) begin n_fail++; $display("FAIL mid_relock_err: got %0b want 0", o_sync_error); end
  endtask

  task automatic test_early_vsync();
    int frames = 0;
    bit seen = 0;
    for (int i = 0; i < 3 * FRAME && frames < 2; i++) begin
      step();
      if (cur_h == 0 && cur_v == 0) frames++;
    end
    n_cmp++; if (frames != 2) begin n_fail++; $display("FAIL early_frames: got %0d want 2", frames); end
    n_cmp++; if (o_frame_start !== 1'b1) begin n_fail++; $display("FAIL early_fs: got %0b want 1", o_frame_start); end
    n_cmp++; if (o_pixel_count !== 19'(EXP_FULL)) begin n_fail++; $display("FAIL full_frame_pc: got %0d want %0d", o_pixel_count, EXP_FULL); end
    skip_pend = 1;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      step();
      seen = (o_sync_error === 1'b1);
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL early_err: got 0 want 1"); end
    n_cmp++; if (cur_h != 0 || cur_v != VSS) begin n_fail++; $display("FAIL early_where: got (%0d,%0d) want (0,%0d)", cur_h, cur_v, VSS); end
    n_cmp++; if (o_vcounter !== 11'(VSS)) begin n_fail++; $display("FAIL early_v: got %0d want %0d", o_vcounter, VSS); end
    n_cmp++; if (o_hcounter !== 11'd0) begin n_fail++; $display("FAIL early_h: got %0d want 0", o_hcounter); end
    n_cmp++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL early_locked: got %0b want 0", o_locked); end
    n_cmp++; if (o_active !== 1'b0) begin n_fail++; $display("FAIL early_active: got %0b want 0", o_active); end
    n_cmp++; if (o_pixel_count !== 19'(EXP_FULL)) begin n_fail++; $display("FAIL early_pc_hold: got %0d want %0d", o_pixel_count, EXP_FULL); end
  endtask

  initial begin
    i_reset = 1'b1; i_pix_en = 1'b0; i_hsync = 1'b1; i_vsync = 1'b1; i_pixel_on = 1'b0;
    test_reset();
    test_lock();
    test_active();
    test_pixel_count();
    test_short_line();
    test_mid_reset();
    test_early_vsync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
